geq2_bist: RTL and testbench
============================

Name: geq2_bist

Overview:
- Hardware stimulus/response engine for the geq2 comparator; the on-chip counterpart of the bench stimulus.
- On `start`, drives every (a, b) operand pair into the comparator and samples its `ageqb` response against a golden `a >= b`.
- Counts mismatches, captures the first failing pair, and reports pass/fail.
- Sits beside the comparator in the lab top level; results go to LEDs/7-seg.

Parameters:
- WIDTH, 2, operand width in bits of the comparator under test.
- SETTLE, 1, cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a run; ignored while busy.
- a  output  WIDTH  operand a driven to comparator.
- b  output  WIDTH  operand b driven to comparator.
- dut_ageqb  input  1  comparator response.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until next start or reset.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  2*WIDTH+1  number of mismatching vectors in the last run.
- fail_a  output  WIDTH  a of the first mismatching vector; 0 if none.
- fail_b  output  WIDTH  b of the first mismatching vector; 0 if none.

Behaviour:
- Reset: reset_n low at a rising edge forces state IDLE, vector counter 0, wait counter 0. All outputs go to 0: a, b, busy, done, pass, err_count, fail_a, fail_b. Applies mid-run too; the run is abandoned and no partial result is kept.
- Vector counter vec is 2*WIDTH bits. Outputs are registered from it: a = vec[2W-1:W], b = vec[W-1:0]. Order is 00/00, 00/01, ..., 11/11 for W=2.
- Expected result: exp = (a >= b), unsigned, computed from the registered a/b.
- FSM states:
  - IDLE: busy=0. On start, clear err_count, fail_a, fail_b, first-fail flag, vec and done; go to APPLY.
  - APPLY: busy=1. Hold the vector for SETTLE cycles using the wait counter, then go to CHECK.
  - CHECK (one cycle): if dut_ageqb != exp, increment err_count. On the first mismatch of the run, capture fail_a/fail_b and set the first-fail flag. If vec is all ones, go to DONE; else vec+1 and return to APPLY.
  - DONE: busy=0, done=1, pass=(err_count==0). Results held. A start in DONE behaves as from IDLE and begins a new run.
- Timing: with start sampled at edge k, DONE is entered at edge k + 2^(2W)*(SETTLE+1). Each vector occupies SETTLE+1 cycles.
- start is ignored while busy, with no restart and no effect on counters.
- err_count cannot overflow: its maximum is 2^(2W), which fits in 2W+1 bits.
- a and b keep the last vector (all ones) while in DONE. They return to 0 only on reset or a new start.
- No combinational path from dut_ageqb to any output.

Decomposition:
- Package geq2_bist_pkg holds:
  - state typedef (IDLE, APPLY, CHECK, DONE);
  - localparam NVEC = 2**(2*WIDTH);
  - count-width helper constants.
- One natural sub-module, bist_wait_cnt: a SETTLE-cycle down-counter with load/expire, reusable for other lab BIST engines. Everything else stays in geq2_bist.

Test Plan:
- Correct comparator, W=2, SETTLE=1, start pulse at edge k -> done rises at edge k+32, busy high for 32 cycles; pass=1, err_count=0, fail_a=fail_b=00.
- Comparator output stuck at 0 -> err_count=10, pass=0, fail_a=00, fail_b=00.
- Comparator output stuck at 1 -> err_count=6, pass=0, fail_a=00, fail_b=01.
- Strict a>b bug (equality wrong) -> err_count=4, pass=0, fail_a=00, fail_b=00.
- Reset mid-run: reset_n low at cycle 10 of a run -> next cycle all outputs 0, state IDLE. A subsequent start runs the full 32 cycles with fresh counts.
- start re-pulsed while busy (cycle 5), then again in DONE -> first re-pulse ignored (done still at k+32); second restarts, clearing done and err_count one cycle later. SETTLE=3 run -> done at k+64.

Source files
------------

// File: rtl/geq2_bist_pkg.sv
// Shared types and sizing helpers for the geq2 comparator BIST engine.
// Pure declarations: no logic, no latency, no flow control.
package geq2_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BIST_WIDTH = 2;
   localparam int NVEC       = 2 ** (2 * BIST_WIDTH);

   // vector counter spans both operands
   function automatic int vec_w(input int width);
      return 2 * width;
   endfunction

   // one extra bit so a run where every vector fails still fits
   function automatic int err_w(input int width);
      return 2 * width + 1;
   endfunction

   function automatic int wait_w(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/geq2_bist_if.sv
// Operand/response and result bundle between the BIST engine and its surroundings.
// No logic; master is the engine, slave is the comparator/lab top side.
interface geq2_bist_if
   import geq2_bist_pkg::*;
#(
   parameter int WIDTH = BIST_WIDTH
);
   logic                      start;
   logic [WIDTH-1:0]          a;
   logic [WIDTH-1:0]          b;
   logic                      dut_ageqb;
   logic                      busy;
   logic                      done;
   logic                      pass;
   logic [err_w(WIDTH)-1:0]   err_count;
   logic [WIDTH-1:0]          fail_a;
   logic [WIDTH-1:0]          fail_b;

   modport master (
      input  start, dut_ageqb,
      output a, b, busy, done, pass, err_count, fail_a, fail_b
   );

   modport slave (
      output start, dut_ageqb,
      input  a, b, busy, done, pass, err_count, fail_a, fail_b
   );
endinterface

// File: rtl/bist_wait_cnt.sv
// Settle down-counter: load arms SETTLE cycles, expire is high on the last one.
// Expire is a pure decode of the count register; dec is ignored once at zero.
module bist_wait_cnt
   import geq2_bist_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic expire
);
   localparam int CW = wait_w(SETTLE);
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/geq2_bist.sv
// Exhaustive stimulus/response engine for the geq2 comparator; each vector takes SETTLE+1 cycles.
// start is only honoured in IDLE/DONE; all outputs are register-driven, none depend on dut_ageqb.
module geq2_bist
   import geq2_bist_pkg::*;
#(
   parameter int WIDTH  = BIST_WIDTH,
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   geq2_bist_if.master io
);
   localparam int VW = vec_w(WIDTH);
   localparam int EW = err_w(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [VW-1:0]    vec;
   logic [EW-1:0]    err_cnt;
   logic [WIDTH-1:0] fa;
   logic [WIDTH-1:0] fb;
   logic             first_seen;
   logic             exp_geq;
   logic             wait_load;
   logic             wait_exp;
   logic             busy;
   logic             done;
   logic             pass;

   assign exp_geq   = (vec[VW-1:WIDTH] >= vec[WIDTH-1:0]);
   // reload the settle counter on every entry into APPLY
   assign wait_load = (state_nxt == APPLY) && (state != APPLY);

   bist_wait_cnt #(.SETTLE(SETTLE)) u_wait (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (wait_load),
      .dec     (state == APPLY),
      .expire  (wait_exp)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (io.start) state_nxt = APPLY;
         APPLY:      if (wait_exp) state_nxt = CHECK;
         CHECK:      state_nxt = (vec == '1) ? DONE : APPLY;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == APPLY) || (state == CHECK);
      done = (state == DONE);
      pass = (state == DONE) && (err_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vec        <= '0;
         err_cnt    <= '0;
         fa         <= '0;
         fb         <= '0;
         first_seen <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (io.start) begin
                  vec        <= '0;
                  err_cnt    <= '0;
                  fa         <= '0;
                  fb         <= '0;
                  first_seen <= 1'b0;
               end
            end
            CHECK: begin
               if (io.dut_ageqb != exp_geq) begin
                  err_cnt <= err_cnt + 1'b1;
                  if (!first_seen) begin
                     fa         <= vec[VW-1:WIDTH];
                     fb         <= vec[WIDTH-1:0];
                     first_seen <= 1'b1;
                  end
               end
               // last vector stays on a/b while results are held
               if (vec != '1) vec <= vec + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign io.a         = vec[VW-1:WIDTH];
   assign io.b         = vec[WIDTH-1:0];
   assign io.busy      = busy;
   assign io.done      = done;
   assign io.pass      = pass;
   assign io.err_count = err_cnt;
   assign io.fail_a    = fa;
   assign io.fail_b    = fb;

endmodule

// File: tb/tb_geq2_bist.sv
// Drives geq2_bist with modelled good/faulty comparators and random fault maps.
// Two engines share one response table: SETTLE=1 and SETTLE=3.
module tb_geq2_bist;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   fails  = 0;
   bit   resp [16];

   always #5 clk = ~clk;

   geq2_bist_if #(.WIDTH(2)) b0 ();
   geq2_bist_if #(.WIDTH(2)) b1 ();

   assign b0.dut_ageqb = resp[{b0.a, b0.b}];
   assign b1.dut_ageqb = resp[{b1.a, b1.b}];

   geq2_bist #(.WIDTH(2), .SETTLE(1)) u_dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (b0)
   );

   geq2_bist #(.WIDTH(2), .SETTLE(3)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (b1)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // 0 good, 1 stuck-0, 2 stuck-1, 3 strict a>b, else random flips
   task automatic set_mode(input int m);
      for (int v = 0; v < 16; v++) begin
         int av = v / 4;
         int bv = v % 4;
         case (m)
            0:       resp[v] = (av >= bv);
            1:       resp[v] = 1'b0;
            2:       resp[v] = 1'b1;
            3:       resp[v] = (av > bv);
            default: resp[v] = (av >= bv) ^ ($urandom_range(0, 3) == 0);
         endcase
      end
   endtask

   task automatic model(output int errs, output int fa, output int fb);
      errs = 0;
      fa   = 0;
      fb   = 0;
      for (int av = 0; av < 4; av++) begin
         for (int bv = 0; bv < 4; bv++) begin
            if (resp[av * 4 + bv] != (av >= bv)) begin
               if (errs == 0) begin
                  fa = av;
                  fb = bv;
               end
               errs++;
            end
         end
      end
   endtask

   task automatic run(input int sel, input int rp, input string tag);
      int settle;
      int cyc;
      int busy_cyc;
      int errs;
      int fa;
      int fb;
      settle = (sel != 0) ? 3 : 1;
      model(errs, fa, fb);
      @(negedge clk);
      if (sel != 0) b1.start = 1'b1; else b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
      b1.start = 1'b0;
      chk({tag, "_busy_at_start"}, int'(sel != 0 ? b1.busy : b0.busy), 1);
      chk({tag, "_done_cleared"}, int'(sel != 0 ? b1.done : b0.done), 0);
      chk({tag, "_err_cleared"}, int'(sel != 0 ? b1.err_count : b0.err_count), 0);
      cyc = 0;
      busy_cyc = 0;
      while (!(sel != 0 ? b1.done : b0.done) && cyc < 1000) begin
         if (sel != 0 ? b1.busy : b0.busy) busy_cyc++;
         if (sel != 0) b1.start = (cyc == rp); else b0.start = (cyc == rp);
         @(negedge clk);
         cyc++;
      end
      b0.start = 1'b0;
      b1.start = 1'b0;
      chk({tag, "_done_cycle"}, cyc, 16 * (settle + 1));
      chk({tag, "_busy_cycles"}, busy_cyc, 16 * (settle + 1));
      chk({tag, "_err_count"}, int'(sel != 0 ? b1.err_count : b0.err_count), errs);
      chk({tag, "_pass"}, int'(sel != 0 ? b1.pass : b0.pass), int'(errs == 0));
      chk({tag, "_fail_a"}, int'(sel != 0 ? b1.fail_a : b0.fail_a), fa);
      chk({tag, "_fail_b"}, int'(sel != 0 ? b1.fail_b : b0.fail_b), fb);
      chk({tag, "_a_held"}, int'(sel != 0 ? b1.a : b0.a), 3);
      chk({tag, "_b_held"}, int'(sel != 0 ? b1.b : b0.b), 3);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a"}, int'(b0.a), 0);
      chk({tag, "_b"}, int'(b0.b), 0);
      chk({tag, "_busy"}, int'(b0.busy), 0);
      chk({tag, "_done"}, int'(b0.done), 0);
      chk({tag, "_pass"}, int'(b0.pass), 0);
      chk({tag, "_err"}, int'(b0.err_count), 0);
      chk({tag, "_fail_a"}, int'(b0.fail_a), 0);
      chk({tag, "_fail_b"}, int'(b0.fail_b), 0);
   endtask

   initial begin
      reset_n  = 1'b0;
      b0.start = 1'b0;
      b1.start = 1'b0;
      set_mode(0);
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;

      set_mode(0);
      run(0, -1, "good");
      set_mode(1);
      run(0, -1, "stuck0");
      chk("stuck0_err_const", int'(b0.err_count), 10);
      set_mode(2);
      run(0, -1, "stuck1");
      chk("stuck1_fail_b_const", int'(b0.fail_b), 1);
      set_mode(3);
      run(0, -1, "strict_gt");
      chk("strict_gt_err_const", int'(b0.err_count), 4);

      // re-pulse while busy must be ignored; next run restarts from DONE
      set_mode(1);
      run(0, 5, "repulse");
      set_mode(0);
      run(0, -1, "restart_from_done");

      for (int i = 0; i < 6; i++) begin
         set_mode(4);
         run(0, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31)) : -1, "random");
      end

      // abandon a run mid-way with errors already counted
      set_mode(1);
      @(negedge clk);
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrun_busy", int'(b0.busy), 1);
      reset_n = 1'b0;
      @(negedge clk);
      check_zero("midrun_reset");
      reset_n = 1'b1;
      set_mode(2);
      run(0, -1, "post_reset");

      set_mode(3);
      run(1, -1, "settle3");
      set_mode(4);
      run(1, int'($urandom_range(0, 63)), "settle3_random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
